// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs an upstream byte stream into LANES*BW-bit words for the downstream
//   datapath. Each accepted byte fills the next lane, or in fill mode is
//   replicated into every remaining lane. A word is emitted when all lanes
//   are filled, or early when in_last closes it (unused upper lanes are zero).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   upstream byte valid
//   in_ready   block can accept a byte this cycle (no dependency on in_valid)
//   in_data    byte value
//   in_fill    replicate in_data into all remaining lanes; completes the word
//   in_last    close the current word after this byte
//   out_valid  assembled word available
//   out_ready  downstream accepts the word
//   out_data   assembled word, lane 0 at bits [BW-1:0]
//   out_count  number of meaningful lanes in out_data (1..LANES)
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no partial word, nothing pending at the output
// ACCUM | partial word in the accumulator (0 < cnt < LANES), output empty
// HOLD  | word presented on out_data; accumulator is empty (cnt == 0)

module byte_word_packer #(
  parameter int LANES = 4,
  parameter int BW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BW-1:0]              in_data,
  input  logic                       in_fill,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BW-1:0]        out_data,
  output logic [$clog2(LANES):0]     out_count
);

  localparam int CNT_W = $clog2(LANES);
  localparam int OCW   = $clog2(LANES) + 1;
  localparam int WW    = LANES * BW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    acc_q, acc_d;
  logic [WW-1:0]    data_q, data_d;
  logic [OCW-1:0]   count_q, count_d;

  logic          accept;
  logic          pop;
  logic          complete;
  logic [WW-1:0] assembled;

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_count = count_q;
  assign in_ready  = !reset && (!out_valid || out_ready);

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign complete = accept && (in_fill || in_last || (cnt_q == CNT_W'(LANES - 1)));

  // Word as it looks once the current byte lands. Lanes below cnt keep the
  // accumulator contents; lanes above are zero unless filling.
  always_comb begin
    assembled = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(cnt_q)) begin
        assembled[i*BW +: BW] = acc_q[i*BW +: BW];
      end else if (i == int'(cnt_q)) begin
        assembled[i*BW +: BW] = in_data;
      end else if (in_fill) begin
        assembled[i*BW +: BW] = in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    count_d = count_q;
    if (complete) begin
      // Also covers pop + completion in the same cycle: stay in HOLD with
      // the new word, giving back-to-back output without a bubble.
      state_d = HOLD;
      data_d  = assembled;
      count_d = in_fill ? OCW'(LANES) : (OCW'(cnt_q) + OCW'(1));
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      // An accept while in HOLD implies a pop, so the output is released.
      state_d = ACCUM;
      acc_d   = assembled;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (pop) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_fill;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  int total = 0;
  int bad   = 0;

  byte_word_packer #(.LANES(4), .BW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_fill   (in_fill),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic f, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_fill  = f;
    in_last  = l;
    cyc();
    in_valid = 1'b0;
    in_fill  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [2:0] c);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_fill = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Fill from empty
    send(8'hA5, 1'b1, 1'b0);
    check_word("fill_a5", 32'hA5A5A5A5, 3'd4);
    out_ready = 1'b1;
    cyc();
    check("pop_a5", 32'(out_valid), 32'd0);

    // Four plain bytes
    send(8'h11, 1'b0, 1'b0);
    check("p11_nv", 32'(out_valid), 32'd0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    check("p33_nv", 32'(out_valid), 32'd0);
    send(8'h44, 1'b0, 1'b0);
    check_word("plain4", 32'h44332211, 3'd4);
    cyc();
    check("pop_plain4", 32'(out_valid), 32'd0);

    // Partial then fill
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    check_word("partfill", 32'hFFFF0201, 3'd4);
    cyc();

    // Early close with last
    send(8'h7E, 1'b0, 1'b1);
    check_word("last1", 32'h0000007E, 3'd1);
    cyc();
    check("pop_last1", 32'(out_valid), 32'd0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b1);
    check_word("last2", 32'h00000201, 3'd2);
    cyc();

    // Last on the final lane behaves like a normal completion
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'hC4, 1'b0, 1'b1);
    check_word("last4", 32'hC4C3C2C1, 3'd4);
    cyc();

    // Backpressure
    out_ready = 1'b0;
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b0);
    check_word("bp_word", 32'h40302010, 3'd4);
    in_valid = 1'b1; in_data = 8'h55; in_fill = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      cyc();
      check_word("bp_hold", 32'h40302010, 3'd4);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    check_word("bp_b2b", 32'h55555555, 3'd4);
    in_data = 8'h66;
    cyc();
    check_word("stream66", 32'h66666666, 3'd4);
    in_data = 8'h77;
    cyc();
    check_word("stream77", 32'h77777777, 3'd4);
    in_valid = 1'b0; in_fill = 1'b0;
    cyc();
    check("stream_end", 32'(out_valid), 32'd0);

    // Reset mid-word, with a word also pending at the output
    out_ready = 1'b0;
    send(8'h99, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    cyc();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(8'h01, 1'b0, 1'b0);
    check("post_rst_nv", 32'(out_valid), 32'd0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    check_word("post_rst", 32'h04030201, 3'd4);
    cyc();
    check("final_pop", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
